ext_mem_responder: RTL and testbench
====================================

# ext_mem_responder

Word-addressed memory responder for the external memory bus driven by the SimpleARM top (`ext_addr`/`ext_wdata`/`ext_rd_en`/`ext_wr_en`/`ext_byte_en` in, `ext_rdata`/`ext_ready` out). It is the target end of that interface and is used in system benches and FPGA builds in place of off-chip memory. It decodes a programmable address window and inserts a configurable number of wait states. It performs byte-enabled writes into local storage and returns read data with a one-cycle ready pulse.

## Interface
- `BASE_ADDR`, default `32'h2000_0000`: first byte address of the window; must be aligned to `DEPTH*4`.
- `DEPTH`, default `1024`: number of 32-bit words; must be a power of 2.
- `WAIT_STATES`, default `2`: extra cycles between acceptance and `ext_ready`; valid range 0–15.
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: asynchronous active-low reset.
- `ext_addr`, input, 32: byte address. Bits [1:0] are ignored.
- `ext_wdata`, input, 32: write data.
- `ext_rd_en`, input, 1: read request.
- `ext_wr_en`, input, 1: write request.
- `ext_byte_en`, input, 4: active-high byte lanes. Bit i maps to bits [8i+7:8i].
- `ext_rdata`, output, 32: read data. Valid in the cycle `ext_ready` is high.
- `ext_ready`, output, 1: one-cycle completion pulse.
- `ext_err`, output, 1: high together with `ext_ready` when the access fell outside the window.

## Operation
- Requester protocol: the requester holds address, data, byte enables and enables stable from request until it sees `ext_ready`. It may drop the request or present a new one in the cycle after `ext_ready`.
- FSM states:
  - IDLE: if `ext_rd_en | ext_wr_en`, latch the request. Go to WAIT if `WAIT_STATES > 0`, otherwise ACCESS.
  - WAIT: decrement the wait counter. At 1, go to ACCESS.
  - ACCESS: perform the storage read or write.
  - RESP: assert `ext_ready` for one cycle, then return to IDLE.
- The request is latched at acceptance. Inputs are not sampled again until the next IDLE.
- Hit test: `(addr & ~(DEPTH*4-1)) == BASE_ADDR`. Word index is `addr[$clog2(DEPTH)+1:2]`.
- Write, hit: update only the lanes selected by the byte enables. `be=4'b0000` is a legal no-op.
- Read, hit: `ext_rdata` is the stored word in all four lanes. Byte enables are ignored on reads.
- Miss: the write is dropped and reads return `32'h0`. `ext_err=1` in the RESP cycle.
- `ext_rd_en` and `ext_wr_en` both high: treated as a write. `ext_err=1`.
- `ext_rdata` holds its last value outside RESP.
- Storage contents are not reset.

## Timing
- Reset values: `ext_ready=0`, `ext_err=0`, `ext_rdata=0`, FSM in IDLE, wait counter 0.
- Request first seen high in IDLE at cycle 0:
  - ACCESS at cycle 1+WAIT_STATES.
  - `ext_ready` high at cycle 2+WAIT_STATES. Total latency is WAIT_STATES+2.
- Writes commit at the end of the ACCESS cycle. A read accepted immediately after a write sees the new data.
- Back-to-back: a new request in the cycle after RESP is accepted in IDLE that cycle. Sustained throughput is one access per WAIT_STATES+3 cycles.
- A request dropped before `ext_ready` is a protocol violation. The access still completes, the ready pulse is still produced, and nothing is checked.
- Reset asserted mid-access:
  - Immediate return to IDLE; ready, err and rdata go to 0.
  - A write not yet past ACCESS is lost. A write that completed ACCESS persists.

## Structure
- Package `ext_bus_pkg` holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP);
  - `EXT_RDATA_MISS = 32'h0`;
  - the width constant for the wait counter (4 bits).
- Sub-module `ext_mem_array`:
  - synchronous single-port DEPTH×32 storage with a per-byte write mask;
  - 1-cycle registered read;
  - maps to block RAM.
- The FSM, hit decode and wait counter live in `ext_mem_responder`.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles. `ext_ready`, `ext_err` and `ext_rdata` are 0, and there is no ready pulse while idle after release.
- Word write/read with `WAIT_STATES=2`:
  - write `32'hCAFE_F00D` to `0x2000_0010` with `be=4'hF`;
  - ready arrives exactly 4 cycles after the request;
  - a read of `0x2000_0010` returns `CAFEF00D` with `err=0`.
- Byte lanes:
  - write `32'hFFFF_FFFF` to `0x2000_0020`;
  - then write `32'h0000_1200` with `be=4'b0010`;
  - a read returns `FFFF12FF`.
- Back-to-back:
  - write `0x1`, `0x2`, `0x3` to three consecutive words, then read all three with no idle gaps;
  - data is `1`, `2`, `3`, with ready pulses 5 cycles apart.
- Miss and conflict:
  - a read of `0x3000_0000` returns 0 with `err=1`;
  - `rd_en` and `wr_en` high together at `0x2000_0004` with data `0xA5` writes `0xA5` with `err=1`.
- Reset mid-write: a write of `0x55` to `0x2000_0008` with reset in the WAIT state produces no ready pulse, and a later read returns the prior contents.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// rtl/ext_bus_pkg.sv - shared types and constants for the external memory bus responder
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } ext_state_e;

  localparam logic [31:0] EXT_RDATA_MISS = 32'h0;
  localparam int          WAIT_CNT_W     = 4;

endpackage

// File: rtl/ext_mem_array.sv
// rtl/ext_mem_array.sv - single-port DEPTHx32 storage with per-byte write mask and registered read
module ext_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - windowed, wait-stated memory target for the external memory bus
module ext_mem_responder
  import ext_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  input  logic        ext_rd_en,
  input  logic        ext_wr_en,
  input  logic [3:0]  ext_byte_en,
  output logic [31:0] ext_rdata,
  output logic        ext_ready,
  output logic        ext_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK = ~(32'(DEPTH * 4) - 32'd1);

  ext_state_e            state, next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [AW-1:0]         req_idx;
  logic [31:0]           req_wdata;
  logic [3:0]            req_be;
  logic                  req_write, req_hit, req_err;
  logic [31:0]           rdata_q, mem_rdata, resp_rdata;
  logic                  mem_en, mem_we;
  logic                  req, hit;

  assign req        = ext_rd_en | ext_wr_en;
  assign hit        = (ext_addr & WIN_MASK) == BASE_ADDR;
  assign resp_rdata = req_hit ? mem_rdata : EXT_RDATA_MISS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt <= WAIT_CNT_W'(1)) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request is captured once at acceptance; inputs are ignored until the next IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_write <= 1'b0;
      req_hit   <= 1'b0;
      req_err   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          req_idx   <= ext_addr[AW+1:2];
          req_wdata <= ext_wdata;
          req_be    <= ext_byte_en;
          req_write <= ext_wr_en;
          req_hit   <= hit;
          req_err   <= ~hit | (ext_rd_en & ext_wr_en);
          wait_cnt  <= WAIT_CNT_W'(WAIT_STATES);
        end
        WAIT: wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
        RESP: if (!req_write) rdata_q <= resp_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    ext_ready = 1'b0;
    ext_err   = 1'b0;
    ext_rdata = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = req_write & req_hit;
      end
      RESP: begin
        ext_ready = 1'b1;
        ext_err   = req_err;
        if (!req_write) ext_rdata = resp_rdata;
      end
      default: ;
    endcase
  end

  ext_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .be    (req_be),
    .addr  (req_idx),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb/tb_ext_mem_responder.sv - self-checking bench for ext_mem_responder
module tb_ext_mem_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          DEP  = 1024;
  localparam int          WS   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ext_addr = '0;
  logic [31:0] ext_wdata = '0;
  logic        ext_rd_en = 1'b0;
  logic        ext_wr_en = 1'b0;
  logic [3:0]  ext_byte_en = '0;
  logic [31:0] ext_rdata;
  logic        ext_ready;
  logic        ext_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] model [int];

  ext_mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_rd_en   (ext_rd_en),
    .ext_wr_en   (ext_wr_en),
    .ext_byte_en (ext_byte_en),
    .ext_rdata   (ext_rdata),
    .ext_ready   (ext_ready),
    .ext_err     (ext_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request at posedge+1 and holds it until the ready pulse is seen.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int rcyc);
    ext_addr = addr; ext_wdata = data; ext_byte_en = be;
    ext_rd_en = rd; ext_wr_en = wr;
    lat = -1; rdata = 'x; err = 1'bx; rcyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ext_ready) begin
        lat = n; rdata = ext_rdata; err = ext_err; rcyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    ext_rd_en = 1'b0; ext_wr_en = 1'b0;
  endtask

  // Reference: window is [BASE, BASE+DEP*4); writes merge selected lanes; misses read 0.
  task automatic do_op(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, output int rcyc);
    logic [31:0] rdata, exp_w;
    logic        err, hit;
    int          lat, idx;
    hit = (addr >= BASE) && (addr < BASE + DEP * 4);
    idx = int'((addr - BASE) / 4);
    access(rd, wr, addr, data, be, rdata, err, lat, rcyc);
    chk({tag, "_lat"}, 32'(lat), 32'(WS + 2));
    chk({tag, "_err"}, {31'b0, err}, {31'b0, !hit || (rd && wr)});
    if (wr) begin
      if (hit) begin
        exp_w = model.exists(idx) ? model[idx] : 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) exp_w[8*i +: 8] = data[8*i +: 8];
        model[idx] = exp_w;
      end
    end else if (!hit) begin
      chk({tag, "_rdata_miss"}, rdata, 32'h0);
    end else if (model.exists(idx)) begin
      chk({tag, "_rdata"}, rdata, model[idx]);
    end
  endtask

  initial begin
    int rc, rc1, rc2, rc3, pulses;
    logic [31:0] a;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ext_ready}, 32'h0);
    chk("rst_err", {31'b0, ext_err}, 32'h0);
    chk("rst_rdata", ext_rdata, 32'h0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (ext_ready) pulses++; end
    chk("idle_no_ready", 32'(pulses), 32'h0);
    @(posedge clk); #1;

    // Word write/read
    do_op("word_wr", 1'b0, 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF, rc);
    do_op("word_rd", 1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'h0, rc);
    @(negedge clk);
    chk("rdata_hold", ext_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Byte lanes
    do_op("lane_wr_full", 1'b0, 1'b1, 32'h2000_0020, 32'hFFFF_FFFF, 4'hF, rc);
    do_op("lane_wr_b1", 1'b0, 1'b1, 32'h2000_0020, 32'h0000_1200, 4'b0010, rc);
    do_op("lane_wr_none", 1'b0, 1'b1, 32'h2000_0020, 32'h0BAD_0BAD, 4'b0000, rc);
    do_op("lane_rd", 1'b1, 1'b0, 32'h2000_0020, 32'h0, 4'hF, rc);
    chk("lane_const", model[8], 32'hFFFF_12FF);

    // Back-to-back
    do_op("b2b_wr1", 1'b0, 1'b1, 32'h2000_0040, 32'h1, 4'hF, rc);
    do_op("b2b_wr2", 1'b0, 1'b1, 32'h2000_0044, 32'h2, 4'hF, rc);
    do_op("b2b_wr3", 1'b0, 1'b1, 32'h2000_0048, 32'h3, 4'hF, rc);
    do_op("b2b_rd1", 1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'hF, rc1);
    do_op("b2b_rd2", 1'b1, 1'b0, 32'h2000_0044, 32'h0, 4'hF, rc2);
    do_op("b2b_rd3", 1'b1, 1'b0, 32'h2000_0048, 32'h0, 4'hF, rc3);
    chk("b2b_gap12", 32'(rc2 - rc1), 32'(WS + 3));
    chk("b2b_gap23", 32'(rc3 - rc2), 32'(WS + 3));

    // Miss and conflict
    do_op("miss_rd", 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF, rc);
    do_op("miss_wr", 1'b0, 1'b1, 32'h2000_1000, 32'hDEAD_BEEF, 4'hF, rc);
    do_op("conflict", 1'b1, 1'b1, 32'h2000_0004, 32'h0000_00A5, 4'hF, rc);
    do_op("conflict_rd", 1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF, rc);

    // Reset mid-write
    do_op("pre_wr", 1'b0, 1'b1, 32'h2000_0008, 32'h1234_5678, 4'hF, rc);
    do_op("pre_rd", 1'b1, 1'b0, 32'h2000_0008, 32'h0, 4'hF, rc);
    ext_addr = 32'h2000_0008; ext_wdata = 32'h55; ext_byte_en = 4'hF;
    ext_wr_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", ext_rdata, 32'h0);
    chk("midrst_ready", {31'b0, ext_ready}, 32'h0);
    pulses = 0;
    repeat (3) begin @(negedge clk); if (ext_ready) pulses++; end
    chk("midrst_no_pulse", 32'(pulses), 32'h0);
    ext_wr_en = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); if (ext_ready) pulses++; end
    chk("midrst_idle", 32'(pulses), 32'h0);
    @(posedge clk); #1;
    do_op("midrst_rd", 1'b1, 1'b0, 32'h2000_0008, 32'h0, 4'hF, rc);

    // Randomized traffic against the reference model
    for (int w = 64; w < 80; w++)
      do_op("rnd_init", 1'b0, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, rc);
    for (int k = 0; k < 40; k++) begin
      int sel, op;
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 9);
      if (sel == 0) a = 32'h4000_0000 | ($urandom & 32'h0000_FFFC);
      else          a = BASE + 32'($urandom_range(64, 79) * 4) + 32'($urandom_range(0, 3));
      if (op < 5)       do_op("rnd_rd", 1'b1, 1'b0, a, $urandom, 4'($urandom), rc);
      else if (op < 9)  do_op("rnd_wr", 1'b0, 1'b1, a, $urandom, 4'($urandom), rc);
      else              do_op("rnd_both", 1'b1, 1'b1, a, $urandom, 4'($urandom), rc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int w = 64; w < 80; w++)
      do_op("rnd_final", 1'b1, 1'b0, BASE + 32'(w * 4), 32'h0, 4'h0, rc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
